stream_to_bram: RTL and testbench

- Capture sink for 32-bit AXI streams. Writes a window of accepted beats into a block RAM port for readback over the bus.
- Sits directly downstream of the BRAM playback source (or a link receiver). Used for loopback checks of the pattern generator and for orbit-aligned snapshots of link data.
- Software drives it through a small arm / abort / length / mode control set and reads status back.

---
 rtl/stream_to_bram.sv | 133 +++++++++++++
 tb/tb_stream_to_bram.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_to_bram.sv
// Capture sink: writes a window of accepted 32-bit AXI-stream beats into a BRAM port.
// Capture starts immediately or at an orbit sync, and runs for a latched length.
module stream_to_bram #(
  parameter int MEM_DEPTH = 2048,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       data_stream_TDATA,
  input  logic              data_stream_TVALID,
  output logic              data_stream_TREADY,
  input  logic              fc_orbitSync,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_mode,
  input  logic [15:0]       capture_len,
  output logic              bram_CLK,
  output logic              bram_RST,
  output logic              bram_EN,
  output logic [3:0]        bram_WE,
  output logic [31:0]       bram_ADDR,
  output logic [31:0]       bram_DIN,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_captured
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t              state, next_state;
  logic [ADDR_W-1:0]   word_addr;
  logic [ADDR_W-1:0]   bram_word;
  logic [ADDR_W:0]     len_eff;
  logic [ADDR_W:0]     len_arm;
  logic                orbit_pending;
  logic                write_now;
  logic                last_word;
  logic                arm_take;
  logic                set_pending;

  assign data_stream_TREADY = 1'b1;
  assign bram_CLK           = clk;
  assign bram_RST           = reset;
  assign bram_ADDR          = 32'(bram_word) << 2;
  assign busy               = (state != S_IDLE);

  // Zero or oversize lengths mean a full-depth capture.
  always_comb begin
    if (capture_len == 16'd0 || {1'b0, capture_len} > 17'(MEM_DEPTH))
      len_arm = (ADDR_W+1)'(MEM_DEPTH);
    else
      len_arm = (ADDR_W+1)'(capture_len);
  end

  // NOTE: every signal gets a default at the top of the block so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    next_state  = state;
    write_now   = 1'b0;
    arm_take    = 1'b0;
    set_pending = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm && !abort) begin
          next_state = S_ARMED;
          arm_take   = 1'b1;
        end
      end
      S_ARMED: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (!trig_mode) begin
          write_now = data_stream_TVALID;
        end else if (fc_orbitSync || orbit_pending) begin
          write_now   = data_stream_TVALID;
          set_pending = !data_stream_TVALID;
        end
      end
      S_CAPTURE: begin
        if (abort) next_state = S_IDLE;
        else       write_now  = data_stream_TVALID;
      end
      default: next_state = S_IDLE;
    endcase
    last_word = write_now && (words_captured == len_eff - (ADDR_W+1)'(1));
    if (write_now) next_state = last_word ? S_IDLE : S_CAPTURE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bram_EN        <= 1'b0;
      bram_WE        <= 4'h0;
      bram_word      <= '0;
      bram_DIN       <= '0;
      word_addr      <= '0;
      words_captured <= '0;
      len_eff        <= '0;
      orbit_pending  <= 1'b0;
      done           <= 1'b0;
    end else begin
      bram_EN <= write_now;
      bram_WE <= {4{write_now}};
      if (write_now) begin
        bram_word      <= word_addr;
        bram_DIN       <= data_stream_TDATA;
        words_captured <= words_captured + (ADDR_W+1)'(1);
        // Saturate rather than wrap; the length clamp keeps writes in range.
        if (word_addr != ADDR_W'(MEM_DEPTH - 1)) word_addr <= word_addr + ADDR_W'(1);
        if (last_word) done <= 1'b1;
      end
      if (set_pending) orbit_pending <= 1'b1;
      if (arm_take) begin
        done           <= 1'b0;
        words_captured <= '0;
        word_addr      <= '0;
        orbit_pending  <= 1'b0;
        len_eff        <= len_arm;
      end
    end
  end

endmodule

// File: tb/tb_stream_to_bram.sv
// Directed self-checking bench for stream_to_bram: immediate/orbit triggers, gaps,
// length clamp, abort, arm/abort collision and asynchronous reset mid-capture.
module tb_stream_to_bram;

  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   tdata;
  logic          tvalid;
  logic          tready;
  logic          orbit;
  logic          arm;
  logic          abort;
  logic          trig_mode;
  logic [15:0]   capture_len;
  logic          bram_clk, bram_rst, bram_en;
  logic [3:0]    bram_we;
  logic [31:0]   bram_addr, bram_din;
  logic          busy, done;
  logic [AW:0]   words_captured;

  int tests  = 0;
  int failed = 0;

  // Write log filled by the monitor.
  logic [31:0] mem_model [0:DEPTH-1];
  int          wr_total = 0;
  int          we_bad   = 0;
  logic [31:0] last_addr = '0;

  stream_to_bram #(.MEM_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .data_stream_TDATA  (tdata),
    .data_stream_TVALID (tvalid),
    .data_stream_TREADY (tready),
    .fc_orbitSync       (orbit),
    .arm                (arm),
    .abort              (abort),
    .trig_mode          (trig_mode),
    .capture_len        (capture_len),
    .bram_CLK           (bram_clk),
    .bram_RST           (bram_rst),
    .bram_EN            (bram_en),
    .bram_WE            (bram_we),
    .bram_ADDR          (bram_addr),
    .bram_DIN           (bram_din),
    .busy               (busy),
    .done               (done),
    .words_captured     (words_captured)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bram_en === 1'b1) begin
      mem_model[bram_addr[12:2]] <= bram_din;
      wr_total                   <= wr_total + 1;
      last_addr                  <= bram_addr;
      if (bram_we !== 4'hF) we_bad <= we_bad + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic mode, input logic [15:0] len);
    trig_mode   = mode;
    capture_len = len;
    arm         = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  int base;
  logic [5:0] gap_pat;

  initial begin
    reset = 1'b1; tdata = '0; tvalid = 1'b0; orbit = 1'b0;
    arm = 1'b0; abort = 1'b0; trig_mode = 1'b0; capture_len = '0;
    tick(); tick();
    check("rst_tready", 32'(tready), 32'd1);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_en",     32'(bram_en), 32'd0);
    check("rst_we",     32'(bram_we), 32'd0);
    check("rst_addr",   bram_addr, 32'd0);
    check("rst_words",  32'(words_captured), 32'd0);
    reset = 1'b0;
    tick();

    // Immediate mode, length 4, continuous beats A0..A5.
    base = wr_total;
    do_arm(1'b0, 16'd4);
    check("imm_busy_armed", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tvalid = 1'b1; tdata = 32'hA0 + 32'(i);
      tick();
      if (i == 3) begin
        check("imm_last_en",    32'(bram_en), 32'd1);
        check("imm_last_addr",  bram_addr, 32'hC);
        check("imm_last_din",   bram_din, 32'hA3);
        check("imm_done",       32'(done), 32'd1);
        check("imm_words",      32'(words_captured), 32'd4);
      end
    end
    tvalid = 1'b0;
    tick();
    check("imm_count", 32'(wr_total - base), 32'd4);
    check("imm_w0", mem_model[0], 32'hA0);
    check("imm_w1", mem_model[1], 32'hA1);
    check("imm_w2", mem_model[2], 32'hA2);
    check("imm_w3", mem_model[3], 32'hA3);
    check("imm_idle", 32'(busy), 32'd0);

    // Orbit trigger coincident with beat 0x15.
    base = wr_total;
    do_arm(1'b1, 16'd3);
    check("orb_done_cleared", 32'(done), 32'd0);
    for (int i = 0; i < 16; i++) begin
      tvalid = 1'b1; tdata = 32'h10 + 32'(i); orbit = (i == 5);
      tick();
    end
    tvalid = 1'b0; orbit = 1'b0;
    tick();
    check("orb_count", 32'(wr_total - base), 32'd3);
    check("orb_w0", mem_model[0], 32'h15);
    check("orb_w1", mem_model[1], 32'h16);
    check("orb_w2", mem_model[2], 32'h17);
    check("orb_last_addr", last_addr, 32'h8);
    check("orb_done", 32'(done), 32'd1);

    // Orbit sync with the stream idle; next valid beat 0x33 is word 0.
    base = wr_total;
    do_arm(1'b1, 16'd3);
    tvalid = 1'b1; tdata = 32'h30; tick();
    tdata = 32'h31; tick();
    tvalid = 1'b0; orbit = 1'b1; tick();
    orbit = 1'b0; tick();
    check("pend_no_write", 32'(wr_total - base), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tvalid = 1'b1; tdata = 32'h33 + 32'(i);
      tick();
    end
    tvalid = 1'b0;
    tick();
    check("pend_count", 32'(wr_total - base), 32'd3);
    check("pend_w0", mem_model[0], 32'h33);
    check("pend_w2", mem_model[2], 32'h35);
    check("pend_words", 32'(words_captured), 32'd3);

    // TVALID gaps: pattern 1,0,0,1,0,1 on data 0x40..0x45.
    base    = wr_total;
    gap_pat = 6'b101001;
    do_arm(1'b0, 16'd3);
    for (int i = 0; i < 6; i++) begin
      tvalid = gap_pat[i]; tdata = 32'h40 + 32'(i);
      tick();
      check($sformatf("gap_en_%0d", i), 32'(bram_en), 32'(gap_pat[i]));
    end
    tvalid = 1'b0;
    tick();
    check("gap_count", 32'(wr_total - base), 32'd3);
    check("gap_w0", mem_model[0], 32'h40);
    check("gap_w1", mem_model[1], 32'h43);
    check("gap_w2", mem_model[2], 32'h45);
    check("gap_done", 32'(done), 32'd1);

    // Length clamp: 0 means full depth.
    base = wr_total;
    do_arm(1'b0, 16'd0);
    for (int i = 0; i < DEPTH + 20; i++) begin
      tvalid = 1'b1; tdata = 32'h1000 + 32'(i);
      tick();
    end
    tvalid = 1'b0;
    tick();
    check("clamp0_count", 32'(wr_total - base), 32'(DEPTH));
    check("clamp0_last_addr", last_addr, 32'h1FFC);
    check("clamp0_done", 32'(done), 32'd1);
    check("clamp0_words", 32'(words_captured), 32'(DEPTH));

    // Oversize length; a change to capture_len after arm must not matter.
    base = wr_total;
    do_arm(1'b0, 16'd5000);
    capture_len = 16'd2;
    for (int i = 0; i < DEPTH + 20; i++) begin
      tvalid = 1'b1; tdata = 32'h2000 + 32'(i);
      tick();
    end
    tvalid = 1'b0;
    tick();
    check("clamp5000_count", 32'(wr_total - base), 32'(DEPTH));
    check("clamp5000_last_addr", last_addr, 32'h1FFC);
    check("clamp5000_last_data", mem_model[DEPTH-1], 32'h2000 + 32'(DEPTH - 1));
    check("clamp5000_done", 32'(done), 32'd1);

    // Abort after 2 of 8 words; the beat on the abort cycle is dropped.
    base = wr_total;
    do_arm(1'b0, 16'd8);
    tvalid = 1'b1; tdata = 32'hB0; tick();
    tdata = 32'hB1; tick();
    tdata = 32'hB2; abort = 1'b1; tick();
    abort = 1'b0;
    check("abort_en", 32'(bram_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_words", 32'(words_captured), 32'd2);
    for (int i = 0; i < 4; i++) begin
      tdata = 32'hB3 + 32'(i);
      tick();
    end
    tvalid = 1'b0;
    tick();
    check("abort_count", 32'(wr_total - base), 32'd2);

    // arm and abort together in IDLE: no capture starts.
    base = wr_total;
    capture_len = 16'd4;
    arm = 1'b1; abort = 1'b1; tick();
    arm = 1'b0; abort = 1'b0;
    check("armabort_busy", 32'(busy), 32'd0);
    tvalid = 1'b1; tdata = 32'hC0; tick(); tick();
    tvalid = 1'b0; tick();
    check("armabort_count", 32'(wr_total - base), 32'd0);

    // Asynchronous reset while a write is being presented.
    do_arm(1'b0, 16'd8);
    tvalid = 1'b1; tdata = 32'hD0; tick();
    tdata = 32'hD1; tick();
    check("prereset_en", 32'(bram_en), 32'd1);
    reset = 1'b1;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_done", 32'(done), 32'd0);
    check("areset_en", 32'(bram_en), 32'd0);
    check("areset_words", 32'(words_captured), 32'd0);
    tvalid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_busy", 32'(busy), 32'd0);
    check("we_always_full", 32'(we_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
